cordic_rotator: RTL and testbench

- Iterative rotation-mode CORDIC. Converts an angle into cos/sin.
- Inverse direction of the existing vectoring-mode angle accumulator: z is driven to zero by its sign, and x/y are rotated, instead of accumulating an angle from the sign of y.
- Sits beside the vectoring datapath in the CORDIC project and shares its arctangent table format.
- One rotation per clock; a start/done handshake frames each conversion.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_atan_lut.sv | 32 +++
 rtl/cordic_rotator.sv | 141 ++++++++++++++
 tb/tb_cordic_rotator.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC datapaths: widths, fixed-point formats,
// the rotation gain and angle constants, and the rotator state encoding.
package cordic_pkg;

  localparam int CORDIC_W = 32;
  localparam int ANG_FRAC = 29;
  localparam int XY_FRAC  = 30;

  localparam logic [31:0] CORDIC_K = 32'h26DD3B6A;
  localparam logic [31:0] ANG_PI   = 32'h6487ED51;
  localparam logic [31:0] ANG_PI_2 = 32'h3243F6A9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent table: atan(2^-i) in Q3.29, shared by the rotation
// and vectoring datapaths.
module cordic_atan_lut
  import cordic_pkg::*;
(
  input  logic [4:0]          i_idx,
  output logic [CORDIC_W-1:0] o_atan
);

  // Table lookup; beyond i = 11 atan(2^-i) equals 2^-i to within rounding.
  always_comb begin
    o_atan = 32'h0000_0000;
    case (i_idx)
      5'd0:    o_atan = 32'h1921FB54;
      5'd1:    o_atan = 32'h0ED63383;
      5'd2:    o_atan = 32'h07D6DD7E;
      5'd3:    o_atan = 32'h03FAB753;
      5'd4:    o_atan = 32'h01FF55BB;
      5'd5:    o_atan = 32'h00FFEAAE;
      5'd6:    o_atan = 32'h007FFD55;
      5'd7:    o_atan = 32'h003FFFAB;
      5'd8:    o_atan = 32'h001FFFF5;
      5'd9:    o_atan = 32'h000FFFFF;
      5'd10:   o_atan = 32'h00080000;
      5'd11:   o_atan = 32'h00040000;
      5'd30:   o_atan = 32'h00000001;
      5'd31:   o_atan = 32'h00000000;
      default: o_atan = 32'h00000001 << (5'(ANG_FRAC) - i_idx);
    endcase
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock turns an angle
// in Q3.29 into cos/sin in Q2.30, framed by a start/done handshake.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int N_ITER = 30,
  parameter int W      = CORDIC_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] angle,
  output logic [W-1:0] cos,
  output logic [W-1:0] sin,
  output logic         busy,
  output logic         done
);

  localparam logic [4:0] LAST_I = 5'(N_ITER - 1);

  cordic_state_e r_state;
  cordic_state_e w_state_nxt;

  logic [4:0]          r_i;
  logic signed [W-1:0] r_x;
  logic signed [W-1:0] r_y;
  logic signed [W-1:0] r_z;
  logic                r_neg;
  logic [W-1:0]        r_cos;
  logic [W-1:0]        r_sin;
  logic                r_busy;
  logic                r_done;

  logic [W-1:0]        w_atan;
  logic signed [W-1:0] w_xsh;
  logic signed [W-1:0] w_ysh;
  logic                w_fold_hi;
  logic                w_fold_lo;

  cordic_atan_lut u_atan_lut (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  assign w_xsh     = r_x >>> r_i;
  assign w_ysh     = r_y >>> r_i;
  // Angles beyond +/-pi/2 are rotated by pi first and the result negated.
  assign w_fold_hi = $signed(angle) > $signed(ANG_PI_2);
  assign w_fold_lo = $signed(angle) < -$signed(ANG_PI_2);

  assign cos  = r_cos;
  assign sin  = r_sin;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (r_i == LAST_I) w_state_nxt = ST_DONE;
        else               w_state_nxt = ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_i    <= 5'd0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_neg  <= 1'b0;
      r_cos  <= '0;
      r_sin  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x    <= $signed(CORDIC_K);
            r_y    <= '0;
            r_i    <= 5'd0;
            r_busy <= 1'b1;
            if (w_fold_hi) begin
              r_z   <= $signed(angle - ANG_PI);
              r_neg <= 1'b1;
            end else if (w_fold_lo) begin
              r_z   <= $signed(angle + ANG_PI);
              r_neg <= 1'b1;
            end else begin
              r_z   <= $signed(angle);
              r_neg <= 1'b0;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          // Drive the residual angle toward zero by its sign.
          if (!r_z[W-1]) begin
            r_x <= r_x - w_ysh;
            r_y <= r_y + w_xsh;
            r_z <= r_z - $signed(w_atan);
          end else begin
            r_x <= r_x + w_ysh;
            r_y <= r_y - w_xsh;
            r_z <= r_z + $signed(w_atan);
          end
          r_i <= r_i + 5'd1;
        end
        ST_DONE: begin
          r_cos  <= r_neg ? -r_x : r_x;
          r_sin  <= r_neg ? -r_y : r_y;
          r_done <= 1'b1;
          r_busy <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotator.sv
// Directed-vector bench for cordic_rotator with hand-computed expectations.
module tb_cordic_rotator;
  import cordic_pkg::*;

  localparam int N   = 30;
  localparam int TOL = 8;

  localparam logic [31:0] ONE      = 32'h1 << XY_FRAC;
  localparam logic [31:0] M_ONE    = 32'hC0000000;
  localparam logic [31:0] ZERO     = 32'h00000000;
  localparam logic [31:0] A_PI6    = 32'h10C15238;
  localparam logic [31:0] A_MPI6   = 32'hEF3EADC8;
  localparam logic [31:0] A_MPI2   = 32'hCDBC0957;
  localparam logic [31:0] A_MPI    = 32'h9B7812AF;
  localparam logic [31:0] COS_PI6  = 32'h376CF5D1;
  localparam logic [31:0] HALF     = 32'h20000000;
  localparam logic [31:0] M_HALF   = 32'hE0000000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] angle;
  logic [31:0] cos_o;
  logic [31:0] sin_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  cordic_rotator #(.N_ITER(N), .W(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .angle (angle),
    .cos   (cos_o),
    .sin   (sin_o),
    .busy  (busy_o),
    .done  (done_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input int tol);
    int diff;
    n_checks++;
    diff = $signed(obs - exp);
    if (diff > tol || diff < -tol) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] ang,
                         input logic [31:0] ec, input logic [31:0] es);
    int edges;
    @(negedge clock);
    angle = ang;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check_val({tag, "_busy"}, 32'(busy_o), 32'd1, 0);
    edges = 0;
    while (!done_o && edges < 4 * N) begin
      @(posedge clock);
      @(negedge clock);
      edges++;
    end
    check_val({tag, "_latency"}, 32'(edges), 32'(N + 1), 0);
    check_val({tag, "_cos"}, cos_o, ec, TOL);
    check_val({tag, "_sin"}, sin_o, es, TOL);
    @(posedge clock);
    @(negedge clock);
    check_val({tag, "_idle"}, {30'd0, busy_o, done_o}, 32'd0, 0);
  endtask

  initial begin
    int e;
    int last;
    int nd;
    logic [31:0] cap_cos;
    logic [31:0] cap_sin;
    logic busy_drop;

    reset = 1'b1;
    start = 1'b0;
    angle = 32'h0;
    #12;
    check_val("rst_cos", cos_o, ZERO, 0);
    check_val("rst_sin", sin_o, ZERO, 0);
    check_val("rst_busy", 32'(busy_o), 32'd0, 0);
    check_val("rst_done", 32'(done_o), 32'd0, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_val("idle_busy", 32'(busy_o), 32'd0, 0);

    convert("zero", ZERO, ONE, ZERO);
    convert("pi6", A_PI6, COS_PI6, HALF);
    convert("mpi6", A_MPI6, COS_PI6, M_HALF);
    convert("pi", ANG_PI, M_ONE, ZERO);
    convert("mpi", A_MPI, M_ONE, ZERO);
    convert("mpi2", A_MPI2, ZERO, M_ONE);

    // Second start while busy must be ignored.
    @(negedge clock);
    angle = ZERO;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    angle = A_PI6;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nd = 0;
    cap_cos = 32'h0;
    cap_sin = 32'h0;
    for (int k = 0; k < 2 * N + 8; k++) begin
      @(negedge clock);
      if (done_o) begin
        nd++;
        cap_cos = cos_o;
        cap_sin = sin_o;
      end
    end
    check_val("ign_done_count", 32'(nd), 32'd1, 0);
    check_val("ign_cos", cap_cos, ONE, TOL);
    check_val("ign_sin", cap_sin, ZERO, TOL);

    // Reset in the middle of a conversion.
    @(negedge clock);
    angle = A_PI6;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check_val("mid_busy", 32'(busy_o), 32'd1, 0);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_cos", cos_o, ZERO, 0);
    check_val("mid_rst_sin", sin_o, ZERO, 0);
    check_val("mid_rst_flags", {30'd0, busy_o, done_o}, 32'd0, 0);
    @(negedge clock);
    reset = 1'b0;
    convert("after_rst", A_PI6, COS_PI6, HALF);

    // Start held high: one conversion every N+2 edges.
    @(negedge clock);
    angle = ZERO;
    start = 1'b1;
    e = 0;
    last = 0;
    nd = 0;
    busy_drop = 1'b0;
    while (nd < 3 && e < 5 * (N + 2)) begin
      @(posedge clock);
      @(negedge clock);
      e++;
      if (!busy_o) busy_drop = 1'b1;
      if (done_o) begin
        nd++;
        check_val("b2b_period", 32'(e - last), 32'(N + 2), 0);
        check_val("b2b_cos", cos_o, ONE, TOL);
        check_val("b2b_sin", sin_o, ZERO, TOL);
        last = e;
      end
    end
    check_val("b2b_count", 32'(nd), 32'd3, 0);
    check_val("b2b_busy_held", 32'(busy_drop), 32'd0, 0);
    start = 1'b0;
    repeat (N + 4) @(negedge clock);
    check_val("b2b_drain", {30'd0, busy_o, done_o}, 32'd0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
